// File: rtl/alu_seq.sv
// Registered accumulator ALU: single-cycle ops plus an optional iterative shift-add MUL.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 1001 passes A like any unused code.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] acc_data_i,
    input  logic [WIDTH-1:0] mem_out_i,
    output logic [WIDTH-1:0] result_o,
    output logic             is_zero_o,
    output logic             carry_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpLda = 4'b0101;
    localparam logic [3:0] OpSub = 4'b1000;
    localparam logic [3:0] OpShl = 4'b1010;
    localparam logic [3:0] OpShr = 4'b1011;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;

    always_comb begin
        sc_res   = acc_data_i;
        sc_carry = 1'b0;
        case (opcode_i)
            OpAdd: {sc_carry, sc_res} = {1'b0, acc_data_i} + {1'b0, mem_out_i};
            OpAnd: sc_res = acc_data_i & mem_out_i;
            OpXor: sc_res = acc_data_i ^ mem_out_i;
            OpLda: sc_res = mem_out_i;
            OpSub: begin
                sc_res   = acc_data_i - mem_out_i;
                sc_carry = acc_data_i < mem_out_i;
            end
            OpShl: {sc_carry, sc_res} = {acc_data_i, 1'b0};
            OpShr: begin
                sc_res   = {1'b0, acc_data_i[WIDTH-1:1]};
                sc_carry = acc_data_i[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OpMul = 4'b1001;

    typedef enum logic {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;

    // Final iteration's partial product feeds the result on the completion edge.
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (opcode_i == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, acc_data_i};
                        mplier_d = mem_out_i;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = StMul;
                    end else begin
                        result_d = sc_res;
                        carry_d  = sc_carry;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = prod_step[WIDTH-1:0];
                    carry_d  = |prod_step[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        zero_d = (result_d == '0);
    end

    assign busy_o = (state_q == StMul);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
`else
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        if (start_i) begin
            result_d = sc_res;
            carry_d  = sc_carry;
            done_d   = 1'b1;
        end
        zero_d = (result_d == '0);
    end

    assign busy_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign result_o  = result_q;
    assign is_zero_o = zero_q;
    assign carry_o   = carry_q;
    assign done_o    = done_q;

endmodule
